// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch into a small FIFO feeding IF.
// Ports: imem_* memory side, redirect* flush, instr_* IF handshake, occupancy.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'hC800_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr_out,
  output logic [31:0]            instr_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic          r_stale;

  logic          w_pop;
  logic          w_push;
  logic          w_req;
  logic [AW+1:0] w_need;

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid & instr_ready;
  assign w_push      = r_inflight & ~r_stale;

  // Slots committed once the outstanding response lands and the pop leaves.
  assign w_need = (AW+2)'(r_count)
                + (AW+2)'(r_inflight)
                - (AW+2)'(w_pop);

  assign w_req     = reset & ~redirect & (w_need < DEPTH_W);
  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign occupancy = r_count;

  always_comb begin
    instr_out = NOP_WORD;
    instr_pc  = 32'h0;
    if (instr_valid) begin
      instr_out = r_data[r_rd_ptr];
      instr_pc  = r_pc[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !redirect && w_push) begin
      r_data[r_wr_ptr] <= imem_rdata;
      r_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_stale       <= 1'b0;
    end else if (redirect) begin
      // The word landing this cycle is dropped with the flush; stale
      // only guards a response still owed to a request made now.
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= w_req;
      r_stale    <= w_req;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
      if (r_inflight) begin
        r_stale <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the synchronous instruction memory and the IF stage. The block generates sequential word-aligned fetch addresses and issues read requests to instruction memory. It buffers the returned words with their PCs in a small FIFO and hands them to IF over a valid/ready handshake. On a redirect (branch), it flushes all buffered and in-flight words and restarts fetching at the new PC.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_WORD, 32'hC800_0000: value driven on instr_out while the queue is empty.

- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  32  byte address of request; bits [1:0] always 00.
- imem_rdata  input  32  read data; valid exactly one cycle after a request.
- redirect  input  1  flush and restart fetch (one-cycle pulse).
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 00.
- instr_valid  output  1  instr_out/instr_pc hold a real instruction.
- instr_ready  input  1  IF accepts the head entry this cycle.
- instr_out  output  32  head instruction word, or NOP_WORD when empty.
- instr_pc  output  32  byte address of instr_out; 0 when empty.
- occupancy  output  $clog2(DEPTH)+1  entries currently stored.

## Operation
- State registers: fetch_pc; FIFO storage with rd_ptr and wr_ptr (wrap modulo DEPTH); count; inflight flag plus inflight_pc; stale flag.
- Request rule: imem_req = 1 when reset is deasserted, redirect = 0, and (count + inflight − pop) < DEPTH, where pop = instr_valid & instr_ready. imem_addr = fetch_pc. On a request: fetch_pc += 4 (wraps at 2^32), inflight is set, and inflight_pc is set to imem_addr.
- Response: in the cycle after a request, imem_rdata is written at wr_ptr with inflight_pc, unless stale = 1. A stale response is discarded, and stale then clears.
- Pop: when instr_valid & instr_ready, rd_ptr advances. Push and pop may occur in the same cycle; count is then unchanged. A full FIFO with a simultaneous pop still accepts a push.
- Redirect (highest priority after reset):
  - count and both pointers clear to 0.
  - fetch_pc is set to {redirect_pc[31:2], 2'b00}.
  - If a response is due next cycle, stale is set.
  - imem_req = 0 in the redirect cycle.
  - A pop in the same cycle is ignored, meaning the head is flushed, not consumed.
  - Fetching resumes in the following cycle.
- Back-to-back redirects: the last one wins. Stale is set only when a response is pending at that moment.
- Output: instr_valid = (count != 0). instr_out and instr_pc come combinationally from the head entry, or NOP_WORD and 0 when empty.

## Timing
- Values while reset = 0, sampled at a clk edge:
  - fetch_pc = RESET_PC; count = 0; pointers = 0; inflight = 0; stale = 0.
  - Outputs: imem_req = 0, instr_valid = 0, instr_out = NOP_WORD, instr_pc = 0, occupancy = 0.
- Reset asserted mid-operation drops all buffered and in-flight data; a response arriving in the following cycle is not written.
- First request: the cycle after reset deasserts.
- First valid instruction: two cycles after reset deasserts. Cycle 0 requests, cycle 1 returns data and writes it, cycle 2 has instr_valid = 1.
- Redirect-to-valid latency: 3 cycles. Cycle R has the redirect, R+1 requests, R+2 writes, R+3 shows the target instruction.
- Steady state with instr_ready held high: one instruction per cycle.
- When full with instr_ready = 0: no requests issue, and occupancy equals DEPTH.

## Test plan
- Reset then stream: memory returns addr ^ 32'hA5A5_0000 and instr_ready = 1 throughout. Required response: imem_addr reads 0,4,8,…; instr_valid rises 2 cycles after reset release; then one instruction per cycle with matching instr_pc.
- Fill and backpressure: hold instr_ready = 0 for 10 cycles. Required response: occupancy saturates at 4, imem_req = 0 while full, and no word is lost or duplicated once ready returns.
- Redirect with a response in flight: pulse redirect with redirect_pc = 32'h0000_0103 while streaming. Required response: the stale word is discarded, the next requests go to 0x100, 0x104, …, and the first valid instr_pc is 0x100 exactly 3 cycles later.
- Simultaneous events: redirect together with pop and push at count = DEPTH. Required response: count = 0 the next cycle, and the old head never reappears.
- Mid-operation reset: assert reset = 0 for 1 cycle with 3 entries queued. Required response: all outputs return to reset values, and refetch starts at RESET_PC.
- Address wrap: redirect to 32'hFFFF_FFFC. Required response: fetch sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
